// File: rtl/cpu_gen2_if.sv
// Instruction-fetch bus between cpu_gen2 and its program memory.
// The CPU holds mem_req and mem_addr stable until the memory answers with mem_valid.
interface cpu_gen2_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/cpu_gen2.sv
// Parametrised 4-register CPU: FETCH/EXEC/HALTED state machine, 16-bit instructions fetched
// over a req/valid handshake, NIO registered output ports and a one-cycle retire strobe.
module cpu_gen2 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NIO    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_gen2_if.master            mem,
  input  logic [NIO*DATA_W-1:0] inputs,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halt,
  output logic                  retire,
  output logic [NIO*DATA_W-1:0] outputs,
  output logic [4*DATA_W-1:0]   regs
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [2:0] OP_SYS = 3'd0;
  localparam logic [2:0] OP_IN  = 3'd1;
  localparam logic [2:0] OP_OUT = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_LI  = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_BZ  = 3'd7;

  state_t                  state_r, state_s;
  logic [ADDR_W-1:0]       pc_r, pc_s;
  logic [15:0]             ir_r, ir_s;
  logic                    mem_req_r, mem_req_s;
  logic                    halt_r, halt_s;
  logic                    retire_r, retire_s;
  logic [NIO*DATA_W-1:0]   outputs_r, outputs_s;
  logic [4*DATA_W-1:0]     regs_r, regs_s;

  logic [2:0]              op_s;
  logic [1:0]              rd_s, rs1_s, rs2_s;
  logic                    hb_s;
  logic [7:0]              imm_s;
  logic [DATA_W-1:0]       rs1_val_s, rs2_val_s, in_val_s;
  logic [ADDR_W-1:0]       pc_inc_s, target_s;

  function automatic logic [DATA_W-1:0] reg_read(input logic [4*DATA_W-1:0] file,
                                                  input logic [1:0] idx);
    return file[idx*DATA_W +: DATA_W];
  endfunction

  assign op_s     = ir_r[2:0];
  assign rd_s     = ir_r[4:3];
  assign rs1_s    = ir_r[6:5];
  assign hb_s     = ir_r[7];
  assign imm_s    = ir_r[15:8];
  assign rs2_s    = ir_r[9:8];
  assign pc_inc_s = pc_r + ADDR_W'(1);
  assign target_s = imm_s[ADDR_W-1:0];

  // Operand fetch: both sources are read from the pre-update register file
  always_comb begin
    rs1_val_s = reg_read(regs_r, rs1_s);
    rs2_val_s = reg_read(regs_r, rs2_s);
  end

  // Input port select; an index at or beyond NIO yields zero
  always_comb begin
    in_val_s = '0;
    for (int p = 0; p < NIO; p++) begin
      in_val_s = (imm_s == 8'(p)) ? inputs[p*DATA_W +: DATA_W] : in_val_s;
    end
  end

  // Next-state and next-output logic of the fetch/execute machine
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    ir_s      = ir_r;
    mem_req_s = mem_req_r;
    halt_s    = halt_r;
    retire_s  = 1'b0;
    outputs_s = outputs_r;
    regs_s    = regs_r;

    case (state_r)
      ST_FETCH: begin
        if (mem_req_r && mem.mem_valid) begin
          ir_s      = mem.mem_rdata;
          mem_req_s = 1'b0;
          state_s   = ST_EXEC;
        end else begin
          mem_req_s = 1'b1;
        end
      end

      ST_EXEC: begin
        retire_s  = 1'b1;
        mem_req_s = 1'b0;
        state_s   = ST_FETCH;
        pc_s      = pc_inc_s;
        case (op_s)
          OP_SYS: begin
            if (hb_s) begin
              halt_s  = 1'b1;
              state_s = ST_HALTED;
              pc_s    = pc_r;
            end else begin
              pc_s = pc_inc_s;
            end
          end
          OP_IN:  regs_s[rd_s*DATA_W +: DATA_W] = in_val_s;
          OP_OUT: begin
            // Out-of-range port leaves every output untouched
            for (int p = 0; p < NIO; p++) begin
              outputs_s[p*DATA_W +: DATA_W] = (imm_s == 8'(p)) ? rs1_val_s
                                                                : outputs_r[p*DATA_W +: DATA_W];
            end
          end
          OP_ADD: regs_s[rd_s*DATA_W +: DATA_W] = rs1_val_s + rs2_val_s;
          OP_SUB: regs_s[rd_s*DATA_W +: DATA_W] = rs1_val_s - rs2_val_s;
          OP_LI:  regs_s[rd_s*DATA_W +: DATA_W] = imm_s[DATA_W-1:0];
          OP_JMP: pc_s = target_s;
          OP_BZ: begin
            if (rs1_val_s == '0) begin
              pc_s = target_s;
            end else begin
              pc_s = pc_inc_s;
            end
          end
          default: pc_s = pc_inc_s;
        endcase
      end

      ST_HALTED: begin
        mem_req_s = 1'b0;
      end

      default: begin
        mem_req_s = 1'b0;
        state_s   = ST_FETCH;
      end
    endcase
  end

  // State register; synchronous reset discards any pending fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      pc_r      <= '0;
      ir_r      <= 16'h0000;
      mem_req_r <= 1'b0;
      halt_r    <= 1'b0;
      retire_r  <= 1'b0;
      outputs_r <= '0;
      regs_r    <= '0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      ir_r      <= ir_s;
      mem_req_r <= mem_req_s;
      halt_r    <= halt_s;
      retire_r  <= retire_s;
      outputs_r <= outputs_s;
      regs_r    <= regs_s;
    end
  end

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = pc_r;
  assign pc           = pc_r;
  assign halt         = halt_r;
  assign retire       = retire_r;
  assign outputs      = outputs_r;
  assign regs         = regs_r;

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed bench for cpu_gen2: small hand-assembled programs with hand-computed results,
// a combinational ROM on the fetch bus and a controllable mem_valid for slow-memory cases.
module tb_cpu_gen2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NIO    = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  valid_en = 1'b1;
  logic [15:0]           rom [256];
  logic [NIO*DATA_W-1:0] inputs = '0;
  logic [ADDR_W-1:0]     pc;
  logic                  halt;
  logic                  retire;
  logic [NIO*DATA_W-1:0] outputs;
  logic [4*DATA_W-1:0]   regs;
  int                    n_tests = 0;
  int                    n_fail  = 0;
  int                    got;
  int                    bad;

  cpu_gen2_if #(.ADDR_W(ADDR_W)) mem_bus ();
  assign mem_bus.mem_rdata = rom[mem_bus.mem_addr];
  assign mem_bus.mem_valid = valid_en;

  cpu_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NIO(NIO)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (mem_bus),
    .inputs  (inputs),
    .pc      (pc),
    .halt    (halt),
    .retire  (retire),
    .outputs (outputs),
    .regs    (regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f_li(input logic [1:0] rd, input logic [7:0] imm);
    return {imm, 1'b0, 2'd0, rd, 3'd5};
  endfunction
  function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2);
    return {6'd0, rs2, 1'b0, rs1, rd, op};
  endfunction
  function automatic logic [15:0] f_in(input logic [1:0] rd, input logic [7:0] port);
    return {port, 1'b0, 2'd0, rd, 3'd1};
  endfunction
  function automatic logic [15:0] f_out(input logic [1:0] rs, input logic [7:0] port);
    return {port, 1'b0, rs, 2'd0, 3'd2};
  endfunction
  function automatic logic [15:0] f_jmp(input logic [7:0] t);
    return {t, 1'b0, 2'd0, 2'd0, 3'd6};
  endfunction
  function automatic logic [15:0] f_bz(input logic [1:0] rs, input logic [7:0] t);
    return {t, 1'b0, rs, 2'd0, 3'd7};
  endfunction

  function automatic logic [7:0] reg_at(input int i);
    return regs[i*DATA_W +: DATA_W];
  endfunction
  function automatic logic [7:0] out_at(input int i);
    return outputs[i*DATA_W +: DATA_W];
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0080;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_retires(input int n, input int budget, output int cnt);
    cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (retire) cnt++;
      if (cnt >= n) break;
    end
  endtask

  task automatic wait_halt(input int budget, output int cnt);
    cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (retire) cnt++;
      if (halt) break;
    end
  endtask

  initial begin
    // Reset state and arithmetic sequence
    clear_rom();
    rom[0] = f_li(2'd1, 8'd5);
    rom[1] = f_li(2'd2, 8'd3);
    rom[2] = f_alu(3'd4, 2'd3, 2'd1, 2'd2);
    rom[3] = f_alu(3'd3, 2'd0, 2'd3, 2'd3);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("req_after_rst", 32'(mem_bus.mem_req), 32'd1);
    check("addr_after_rst", 32'(mem_bus.mem_addr), 32'd0);
    check("regs_after_rst", regs, 32'd0);
    check("outputs_after_rst", outputs, 32'd0);
    check("halt_after_rst", 32'(halt), 32'd0);
    wait_retires(4, 60, got);
    check("arith_retires", 32'(got), 32'd4);
    check("arith_r3", 32'(reg_at(3)), 32'h02);
    check("arith_r0", 32'(reg_at(0)), 32'h04);
    check("arith_r1", 32'(reg_at(1)), 32'h05);
    check("arith_pc", 32'(pc), 32'd4);

    // Modular wrap: 0-1 and 0xFF+1
    clear_rom();
    rom[0] = f_li(2'd1, 8'd0);
    rom[1] = f_li(2'd2, 8'd1);
    rom[2] = f_alu(3'd4, 2'd3, 2'd1, 2'd2);
    rom[3] = f_alu(3'd3, 2'd3, 2'd3, 2'd2);
    do_reset();
    wait_retires(3, 60, got);
    check("wrap_sub_retires", 32'(got), 32'd3);
    check("wrap_sub_r3", 32'(reg_at(3)), 32'hFF);
    wait_retires(1, 20, got);
    check("wrap_add_r3", 32'(reg_at(3)), 32'h00);

    // Countdown loop ending in HALT
    clear_rom();
    rom[0] = f_li(2'd0, 8'd3);
    rom[1] = f_li(2'd1, 8'd1);
    rom[2] = f_bz(2'd0, 8'd6);
    rom[3] = f_alu(3'd4, 2'd0, 2'd0, 2'd1);
    rom[4] = f_jmp(8'd2);
    do_reset();
    wait_halt(400, got);
    check("loop_halt", 32'(halt), 32'd1);
    check("loop_pc", 32'(pc), 32'd6);
    check("loop_retires", 32'(got), 32'd13);
    check("loop_r0", 32'(reg_at(0)), 32'h00);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (retire || mem_bus.mem_req || pc != 8'd6 || !halt) bad++;
    end
    check("halted_quiet", 32'(bad), 32'd0);

    // I/O ports, out-of-range port indices; reset also clears halt
    clear_rom();
    inputs = {8'h33, 8'hA5, 8'h22, 8'h11};
    rom[0] = f_li(2'd0, 8'h77);
    rom[1] = f_in(2'd2, 8'd2);
    rom[2] = f_out(2'd2, 8'd3);
    rom[3] = f_out(2'd2, 8'd9);
    rom[4] = f_in(2'd0, 8'd7);
    rom[5] = f_in(2'd1, 8'd0);
    do_reset();
    check("reset_clears_halt", 32'(halt), 32'd0);
    check("reset_clears_pc", 32'(pc), 32'd0);
    wait_halt(200, got);
    check("io_retires", 32'(got), 32'd7);
    check("io_r2", 32'(reg_at(2)), 32'hA5);
    check("io_r0_oob", 32'(reg_at(0)), 32'h00);
    check("io_r1", 32'(reg_at(1)), 32'h11);
    check("io_out3", 32'(out_at(3)), 32'hA5);
    check("io_out_others", 32'(outputs[3*DATA_W-1:0]), 32'd0);

    // Slow memory, then reset during the wait
    clear_rom();
    rom[0] = f_li(2'd1, 8'd9);
    rom[1] = f_li(2'd2, 8'd7);
    rom[2] = f_li(2'd3, 8'd5);
    do_reset();
    wait_retires(2, 40, got);
    check("slow_pre_retires", 32'(got), 32'd2);
    check("slow_pre_pc", 32'(pc), 32'd2);
    valid_en = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!mem_bus.mem_req || mem_bus.mem_addr != 8'd2 || retire) bad++;
    end
    check("slow_wait_stable", 32'(bad), 32'd0);
    check("slow_wait_r3", 32'(reg_at(3)), 32'h00);
    rst = 1'b1;
    valid_en = 1'b1;
    @(negedge clk);
    check("midwait_rst_req", 32'(mem_bus.mem_req), 32'd0);
    check("midwait_rst_pc", 32'(pc), 32'd0);
    check("midwait_rst_regs", regs, 32'd0);
    rst = 1'b0;
    wait_retires(1, 20, got);
    check("restart_r1", 32'(reg_at(1)), 32'h09);
    check("restart_pc", 32'(pc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
